// File: rtl/sram_emulator.sv
// sram_emulator
// Stands in for an external async SRAM on the frame-buffer controller's pin
// interface. Words live in on-chip RAM and every host cycle is decoded on the
// rising edge of sram_clk, so the controller can be connected unchanged.
//
// Optional feature: define SRAM_EMU_CLEAR_EN to add a clear sweep after reset
// that writes CLEAR_VALUE to every word (ready is held low while it runs).
//
// Ports:
//   sram_clk     100 MHz SRAM clock, all state updates on its rising edge
//   reset        synchronous, active-high
//   SRAM_CE      chip enable, active low
//   SRAM_UB      upper-byte enable, active low
//   SRAM_LB      lower-byte enable, active low
//   SRAM_OE      output enable, active low
//   SRAM_WE      write enable, active low
//   SRAM_ADDR    word address
//   SRAM_DQ      bidirectional data bus, driven only during reads
//   ready        high when host accesses are serviced
//   contention   sticky flag: OE and WE were both low in one serviced cycle
//   wr_count     saturating count of serviced write cycles
//   rd_count     saturating count of serviced read cycles
module sram_emulator #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned READ_LATENCY = 0,
    parameter logic [15:0] CLEAR_VALUE  = 16'h0000
) (
    input  logic              sram_clk,
    input  logic              reset,
    input  logic              SRAM_CE,
    input  logic              SRAM_UB,
    input  logic              SRAM_LB,
    input  logic              SRAM_OE,
    input  logic              SRAM_WE,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              ready,
    output logic              contention,
    output logic [31:0]       wr_count,
    output logic [31:0]       rd_count
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [15:0] mem_q [Depth];

    // Host decode
    logic        sel;
    logic        wr_cyc;
    logic        rd_cyc;
    logic        both_low;
    logic [1:0]  lanes;

    // Clear sweep interface (tied off when the sweep is not built)
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [15:0]       clr_data;

    // Memory write port
    logic              mem_we;
    logic [1:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    // Latency-1 read pipeline
    logic        rd_pend_q;
    logic [1:0]  rd_lanes_q;
    logic [15:0] rd_data_q;

    // Counters and flags
    logic [31:0] wr_count_q, wr_count_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic        contention_q, contention_d;

    // Bus drive
    logic [1:0]  dq_oe;
    logic [15:0] dq_out;

    assign clr_data = CLEAR_VALUE;

`ifdef SRAM_EMU_CLEAR_EN
    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                clr_addr_d = clr_addr_q;
            end
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        ready    = (state_q == StReady);
        clr_we   = (state_q == StClear) && !reset;
        clr_addr = clr_addr_q;
    end
`else
    logic ready_q;

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready    = ready_q;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // Reset also blocks host decode so nothing is driven or written mid-reset.
    assign sel      = ready && !reset && !SRAM_CE;
    assign wr_cyc   = sel && !SRAM_WE;
    assign rd_cyc   = sel && SRAM_WE && !SRAM_OE;
    assign both_low = sel && !SRAM_WE && !SRAM_OE;
    assign lanes    = {~SRAM_UB, ~SRAM_LB};

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_addr  = SRAM_ADDR;
        mem_wdata = SRAM_DQ;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_be    = 2'b11;
            mem_addr  = clr_addr;
            mem_wdata = clr_data;
        end else if (wr_cyc) begin
            // UB=LB=1 leaves both lanes untouched but is still a write cycle.
            mem_we = 1'b1;
            mem_be = lanes;
        end
    end

    always_ff @(posedge sram_clk) begin
        if (mem_we) begin
            if (mem_be[1]) begin
                mem_q[mem_addr][15:8] <= mem_wdata[15:8];
            end
            if (mem_be[0]) begin
                mem_q[mem_addr][7:0] <= mem_wdata[7:0];
            end
        end
    end

    // A write always lands at the edge before a following read registers the
    // word, so write-then-read returns the new data without any bypass.
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            rd_lanes_q <= 2'b00;
            rd_data_q  <= 16'h0000;
        end else begin
            rd_pend_q <= rd_cyc;
            if (rd_cyc) begin
                rd_lanes_q <= lanes;
                rd_data_q  <= mem_q[SRAM_ADDR];
            end
        end
    end

    always_comb begin
        wr_count_d   = wr_count_q;
        rd_count_d   = rd_count_q;
        contention_d = contention_q;
        if (wr_cyc && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end
        if (rd_cyc && (rd_count_q != 32'hFFFF_FFFF)) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (both_low) begin
            contention_d = 1'b1;
        end
    end

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            wr_count_q   <= 32'd0;
            rd_count_q   <= 32'd0;
            contention_q <= 1'b0;
        end else begin
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
            contention_q <= contention_d;
        end
    end

    assign wr_count   = wr_count_q;
    assign rd_count   = rd_count_q;
    assign contention = contention_q;

    always_comb begin
        dq_oe  = 2'b00;
        dq_out = 16'h0000;
        if (READ_LATENCY == 0) begin
            if (rd_cyc) begin
                dq_oe  = lanes;
                dq_out = mem_q[SRAM_ADDR];
            end
        end else if (rd_pend_q && ready && !reset && !wr_cyc) begin
            // Registered data holds the bus for the whole following cycle
            // unless the host starts a write, which needs the bus.
            dq_oe  = rd_lanes_q;
            dq_out = rd_data_q;
        end
    end

    assign SRAM_DQ[15:8] = dq_oe[1] ? dq_out[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = dq_oe[0] ? dq_out[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_emulator.sv
module tb_sram_emulator;

`ifdef SRAM_EMU_CLEAR_EN
    localparam bit ClearEn = 1'b1;
`else
    localparam bit ClearEn = 1'b0;
`endif

    // Pin patterns {CE, UB, LB, OE, WE}
    localparam logic [4:0] PW  = 5'b00010;
    localparam logic [4:0] PWL = 5'b01010;
    localparam logic [4:0] PR  = 5'b00001;
    localparam logic [4:0] PRU = 5'b00101;
    localparam logic [4:0] PRL = 5'b01001;
    localparam logic [4:0] PI  = 5'b00011;
    localparam logic [4:0] PD  = 5'b10011;
    localparam logic [4:0] PDR = 5'b10001;
    localparam logic [4:0] PDW = 5'b10010;
    localparam logic [4:0] PX  = 5'b00000;

    typedef struct {
        logic [4:0]  p;
        logic [9:0]  a;
        logic        hen;
        logic [15:0] hdq;
        logic [15:0] e0;
        logic [1:0]  m0;
        logic [15:0] e1;
        logic [1:0]  m1;
    } vec_t;

    logic        sram_clk = 1'b0;
    logic        reset;
    logic        ce, ub, lb, oe, we;
    logic [9:0]  addr;
    logic        host_en;
    logic [15:0] host_dq;
    wire  [15:0] dq0, dq1, dq2;

    logic        ready0, ready1, ready2;
    logic        cont0, cont1, cont2;
    logic [31:0] wr0, wr1, wr2, rd0, rd1, rd2;

    int total = 0;
    int bad   = 0;
    vec_t tbl [16];

    assign dq0 = host_en ? host_dq : 16'hzzzz;
    assign dq1 = host_en ? host_dq : 16'hzzzz;
    assign dq2 = host_en ? host_dq : 16'hzzzz;

    always #5 sram_clk = ~sram_clk;

    sram_emulator #(.ADDR_W(10), .READ_LATENCY(0), .CLEAR_VALUE(16'h0000)) u_dut0 (
        .sram_clk(sram_clk), .reset(reset), .SRAM_CE(ce), .SRAM_UB(ub), .SRAM_LB(lb),
        .SRAM_OE(oe), .SRAM_WE(we), .SRAM_ADDR(addr), .SRAM_DQ(dq0), .ready(ready0),
        .contention(cont0), .wr_count(wr0), .rd_count(rd0)
    );

    sram_emulator #(.ADDR_W(10), .READ_LATENCY(1), .CLEAR_VALUE(16'h0000)) u_dut1 (
        .sram_clk(sram_clk), .reset(reset), .SRAM_CE(ce), .SRAM_UB(ub), .SRAM_LB(lb),
        .SRAM_OE(oe), .SRAM_WE(we), .SRAM_ADDR(addr), .SRAM_DQ(dq1), .ready(ready1),
        .contention(cont1), .wr_count(wr1), .rd_count(rd1)
    );

    sram_emulator #(.ADDR_W(4), .READ_LATENCY(0), .CLEAR_VALUE(16'h0F0F)) u_dut2 (
        .sram_clk(sram_clk), .reset(reset), .SRAM_CE(ce), .SRAM_UB(ub), .SRAM_LB(lb),
        .SRAM_OE(oe), .SRAM_WE(we), .SRAM_ADDR(addr[3:0]), .SRAM_DQ(dq2), .ready(ready2),
        .contention(cont2), .wr_count(wr2), .rd_count(rd2)
    );

    function automatic vec_t mkv(input logic [4:0] p, input logic [9:0] a, input logic hen,
                                 input logic [15:0] hdq, input logic [15:0] e0,
                                 input logic [1:0] m0, input logic [15:0] e1,
                                 input logic [1:0] m1);
        vec_t v;
        v.p = p; v.a = a; v.hen = hen; v.hdq = hdq;
        v.e0 = e0; v.m0 = m0; v.e1 = e1; v.m1 = m1;
        return v;
    endfunction

    // Lanes in m must match exp; other lanes must not be driven to 1.
    task automatic chk_bus(input string name, input logic [15:0] act,
                           input logic [15:0] exp, input logic [1:0] m);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (m[i >= 8]) begin
                if (act[i] !== exp[i]) ok = 1'b0;
            end else if (act[i] === 1'b1) begin
                ok = 1'b0;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: bus=%h required=%h on lanes %b (others released)",
                     name, act, exp, m);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pins(input logic [4:0] p, input logic [9:0] a, input logic hen,
                        input logic [15:0] hdq);
        @(negedge sram_clk);
        {ce, ub, lb, oe, we} = p;
        addr    = a;
        host_en = hen;
        host_dq = hdq;
        #2;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!(ready0 && ready1) && n < 4000) begin
            @(negedge sram_clk);
            n++;
        end
        chk32("ready wait", {30'd0, ready1, ready0}, 32'd3);
    endtask

    task automatic do_reset();
        pins(PD, 10'd0, 1'b0, 16'h0000);
        reset = 1'b1;
        @(negedge sram_clk);
        @(negedge sram_clk);
        reset = 1'b0;
        wait_ready();
        #2;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (!ready2 && n < 100) begin
            n++;
            @(negedge sram_clk);
        end
        chk32(name, n, ClearEn ? 32'd16 : 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {ce, ub, lb, oe, we} = PD;
        addr = 10'd0; host_en = 1'b0; host_dq = 16'h0000; reset = 1'b1;

        tbl[0]  = mkv(PW,  10'h123, 1'b1, 16'hBEEF, 16'hBEEF, 2'b11, 16'hBEEF, 2'b11);
        tbl[1]  = mkv(PR,  10'h123, 1'b0, 16'h0000, 16'hBEEF, 2'b11, 16'h0000, 2'b00);
        tbl[2]  = mkv(PW,  10'h005, 1'b1, 16'h1234, 16'h1234, 2'b11, 16'h1234, 2'b11);
        tbl[3]  = mkv(PWL, 10'h005, 1'b1, 16'hABCD, 16'hABCD, 2'b11, 16'hABCD, 2'b11);
        tbl[4]  = mkv(PR,  10'h005, 1'b0, 16'h0000, 16'h12CD, 2'b11, 16'h0000, 2'b00);
        tbl[5]  = mkv(PRU, 10'h005, 1'b0, 16'h0000, 16'h12CD, 2'b10, 16'h12CD, 2'b11);
        tbl[6]  = mkv(PRL, 10'h005, 1'b0, 16'h0000, 16'h12CD, 2'b01, 16'h12CD, 2'b10);
        tbl[7]  = mkv(PI,  10'h005, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h12CD, 2'b01);
        tbl[8]  = mkv(PDR, 10'h005, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 2'b00);
        tbl[9]  = mkv(PW,  10'h007, 1'b1, 16'h00FF, 16'h00FF, 2'b11, 16'h00FF, 2'b11);
        tbl[10] = mkv(PR,  10'h007, 1'b0, 16'h0000, 16'h00FF, 2'b11, 16'h0000, 2'b00);
        tbl[11] = mkv(PD,  10'h007, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h00FF, 2'b11);
        tbl[12] = mkv(PD,  10'h007, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 2'b00);
        tbl[13] = mkv(PDW, 10'h005, 1'b1, 16'hFFFF, 16'hFFFF, 2'b11, 16'hFFFF, 2'b11);
        tbl[14] = mkv(PR,  10'h005, 1'b0, 16'h0000, 16'h12CD, 2'b11, 16'h0000, 2'b00);
        tbl[15] = mkv(PD,  10'h005, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h12CD, 2'b11);

        // Reset state
        repeat (2) @(negedge sram_clk);
        chk32("rst ready", {29'd0, ready2, ready1, ready0}, 32'd0);
        chk32("rst contention", {29'd0, cont2, cont1, cont0}, 32'd0);
        chk32("rst wr_count0", wr0, 32'd0);
        chk32("rst rd_count0", rd0, 32'd0);
        chk32("rst counts1", wr1 | rd1, 32'd0);
        chk32("rst counts2", wr2 | rd2, 32'd0);
        chk_bus("rst dq0", dq0, 16'h0000, 2'b00);
        reset = 1'b0;
        @(negedge sram_clk);
        chk32("ready after rst", {31'd0, ready0}, ClearEn ? 32'd0 : 32'd1);
        wait_ready();

        for (int i = 0; i < 16; i++) begin
            pins(tbl[i].p, tbl[i].a, tbl[i].hen, tbl[i].hdq);
            chk_bus($sformatf("vec%0d dq0", i), dq0, tbl[i].e0, tbl[i].m0);
            chk_bus($sformatf("vec%0d dq1", i), dq1, tbl[i].e1, tbl[i].m1);
        end
        pins(PD, 10'd0, 1'b0, 16'h0000);
        chk32("table wr_count0", wr0, 32'd4);
        chk32("table rd_count0", rd0, 32'd6);
        chk32("table wr_count1", wr1, 32'd4);
        chk32("table rd_count1", rd1, 32'd6);
        chk32("table contention", {31'd0, cont0}, 32'd0);

        // Contention: treated as a write, bus left to the host
        pins(PW, 10'h009, 1'b1, 16'hAAAA);
        chk_bus("pre-contention write dq0", dq0, 16'hAAAA, 2'b11);
        pins(PX, 10'h009, 1'b1, 16'h5555);
        chk32("contention before edge", {31'd0, cont0}, 32'd0);
        chk_bus("contention dq0", dq0, 16'h5555, 2'b11);
        chk_bus("contention dq1", dq1, 16'h5555, 2'b11);
        pins(PR, 10'h009, 1'b0, 16'h0000);
        chk_bus("read after contention dq0", dq0, 16'h5555, 2'b11);
        chk32("contention set", {30'd0, cont1, cont0}, 32'd3);
        pins(PD, 10'd0, 1'b0, 16'h0000);
        chk_bus("read after contention dq1", dq1, 16'h5555, 2'b11);
        chk32("contention wr_count0", wr0, 32'd6);
        chk32("contention rd_count0", rd0, 32'd7);
        repeat (3) pins(PD, 10'd0, 1'b0, 16'h0000);
        chk32("contention sticky", {31'd0, cont0}, 32'd1);

        do_reset();
        chk32("post-rst contention", {30'd0, cont1, cont0}, 32'd0);
        chk32("post-rst wr_count0", wr0, 32'd0);
        chk32("post-rst rd_count0", rd0, 32'd0);

        // Saturation of the write counter
        @(negedge sram_clk);
        force u_dut0.wr_count_q = 32'hFFFF_FFFE;
        #1;
        release u_dut0.wr_count_q;
        repeat (3) pins(PW, 10'h014, 1'b1, 16'h1111);
        pins(PD, 10'd0, 1'b0, 16'h0000);
        chk32("saturated wr_count0", wr0, 32'hFFFF_FFFF);
        chk32("unsaturated wr_count1", wr1, 32'd3);

        // Clear sweep length, restart on mid-sweep reset, memory result
        pins(PW, 10'h003, 1'b1, 16'hAAAA);
        pins(PR, 10'h003, 1'b0, 16'h0000);
        chk_bus("pre-clear dq2", dq2, 16'hAAAA, 2'b11);
        pins(PD, 10'd0, 1'b0, 16'h0000);
        reset = 1'b1;
        @(negedge sram_clk);
        reset = 1'b0;
        count_clear("clear length");
        reset = 1'b1;
        @(negedge sram_clk);
        reset = 1'b0;
        repeat (8) @(negedge sram_clk);
        chk32("mid-sweep ready", {31'd0, ready2}, ClearEn ? 32'd0 : 32'd1);
        reset = 1'b1;
        @(negedge sram_clk);
        reset = 1'b0;
        count_clear("clear restart length");
        pins(PR, 10'h003, 1'b0, 16'h0000);
        chk_bus("post-clear dq2", dq2, ClearEn ? 16'h0F0F : 16'hAAAA, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
